// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the front end: the opcodes the core implements,
// the canonical NOP encoding and the fetch FSM state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

    // Force an address onto a word boundary so the PC low bits stay zero.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_legal_chk.sv
// Combinational opcode legality check: legal=1 when op is one of the
// opcodes implemented by the core.
module instr_legal_chk
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic       legal
);

    // Match the opcode against the implemented set.
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_LOAD,
            OP_STORE,
            OP_RTYPE,
            OP_BRANCH,
            OP_ITYPE,
            OP_JAL:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: IDLE -> REQ -> VALID handshake FSM that requests a
// word from instruction memory, holds it for decode, and follows redirects
// from execute. Peak rate is one instruction every two cycles.
// Optional macro FETCH_ILLEGAL_CHECK_EN adds the IllegalInstr output, which
// flags an unimplemented opcode in the word presented to decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRData,
    input  logic        Redirect,
    input  logic [31:0] PCTarget,
    output logic [31:0] Instr,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValid,
    input  logic        InstrReady
`ifdef FETCH_ILLEGAL_CHECK_EN
    ,
    output logic        IllegalInstr
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and held-instruction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= align_word(RESET_PC);
            instr_q <= NOP_INSTR;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next state and next PC/instruction; Redirect beats both ImemAck and
    // InstrReady, and an ack coinciding with a redirect is dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (Redirect) begin
                    pc_d    = align_word(PCTarget);
                    state_d = REQ;
                end else if (ImemAck) begin
                    instr_d = ImemRData;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (Redirect) begin
                    pc_d    = align_word(PCTarget);
                    state_d = REQ;
                end else if (InstrReady) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        ImemReq    = 1'b0;
        InstrValid = 1'b0;
        case (state_q)
            REQ:     ImemReq    = 1'b1;
            VALID:   InstrValid = 1'b1;
            default: begin
                ImemReq    = 1'b0;
                InstrValid = 1'b0;
            end
        endcase
    end

    assign ImemAddr = pc_q;
    assign PCF      = pc_q;
    assign PCPlus4F = pc_q + 32'd4;
    assign Instr    = instr_q;

`ifdef FETCH_ILLEGAL_CHECK_EN
    logic op_legal;

    instr_legal_chk u_legal (
        .op    (instr_q[6:0]),
        .legal (op_legal)
    );

    assign IllegalInstr = InstrValid & ~op_legal;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table walks the FSM through
// back-to-back fetches, a delayed ack, a decode stall and redirects; hand
// sequences cover async reset mid-transaction and PC wrap-around.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemRData = 32'h0;
    logic        Redirect = 1'b0;
    logic [31:0] PCTarget = 32'h0;
    logic [31:0] Instr;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValid;
    logic        InstrReady = 1'b0;

    logic        rst2 = 1'b1;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] pc4_2;
    logic        valid2;

`ifdef FETCH_ILLEGAL_CHECK_EN
    logic        IllegalInstr;
    logic        illegal2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemAck    (ImemAck),
        .ImemRData  (ImemRData),
        .Redirect   (Redirect),
        .PCTarget   (PCTarget),
        .Instr      (Instr),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady)
`ifdef FETCH_ILLEGAL_CHECK_EN
        ,
        .IllegalInstr (IllegalInstr)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk        (clk),
        .reset      (rst2),
        .ImemReq    (req2),
        .ImemAddr   (addr2),
        .ImemAck    (1'b1),
        .ImemRData  (32'h0000_0013),
        .Redirect   (1'b0),
        .PCTarget   (32'h0),
        .Instr      (instr2),
        .PCF        (pc2),
        .PCPlus4F   (pc4_2),
        .InstrValid (valid2),
        .InstrReady (1'b1)
`ifdef FETCH_ILLEGAL_CHECK_EN
        ,
        .IllegalInstr (illegal2)
`endif
    );

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic redir, input logic [31:0] tgt,
                                input logic ack, input logic [31:0] rdata,
                                input logic ready, input logic e_req,
                                input logic [31:0] e_pc, input logic e_valid,
                                input logic [31:0] e_instr);
        vec_t v;
        v.redir = redir;  v.tgt = tgt;      v.ack = ack;
        v.rdata = rdata;  v.ready = ready;  v.e_req = e_req;
        v.e_pc = e_pc;    v.e_valid = e_valid; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic e_req, input logic [31:0] e_pc,
                            input logic e_valid, input logic [31:0] e_instr);
        chk({tag, " ImemReq"},    {31'd0, ImemReq},    {31'd0, e_req});
        chk({tag, " ImemAddr"},   ImemAddr,            e_pc);
        chk({tag, " PCF"},        PCF,                 e_pc);
        chk({tag, " PCPlus4F"},   PCPlus4F,            e_pc + 32'd4);
        chk({tag, " InstrValid"}, {31'd0, InstrValid}, {31'd0, e_valid});
        chk({tag, " Instr"},      Instr,               e_instr);
    endtask

    initial begin
        //            redir tgt          ack rdata         rdy  req pc           vld instr
        vecs[0]  = mk(1'b1, 32'h200,     0, 32'h0,         0,   0, 32'h0,        0, 32'h13);
        vecs[1]  = mk(0,    32'h0,       1, 32'hA000_0000, 1,   1, 32'h0,        0, 32'h13);
        vecs[2]  = mk(0,    32'h0,       0, 32'h0,         1,   0, 32'h0,        1, 32'hA000_0000);
        vecs[3]  = mk(0,    32'h0,       1, 32'hA000_0004, 1,   1, 32'h4,        0, 32'hA000_0000);
        vecs[4]  = mk(0,    32'h0,       0, 32'h0,         1,   0, 32'h4,        1, 32'hA000_0004);
        vecs[5]  = mk(0,    32'h0,       1, 32'hA000_0008, 1,   1, 32'h8,        0, 32'hA000_0004);
        vecs[6]  = mk(0,    32'h0,       0, 32'h0,         1,   0, 32'h8,        1, 32'hA000_0008);
        vecs[7]  = mk(0,    32'h0,       1, 32'hA000_000C, 1,   1, 32'hC,        0, 32'hA000_0008);
        vecs[8]  = mk(0,    32'h0,       0, 32'h0,         1,   0, 32'hC,        1, 32'hA000_000C);
        vecs[9]  = mk(0,    32'h0,       0, 32'hDEAD_0000, 0,   1, 32'h10,       0, 32'hA000_000C);
        vecs[10] = mk(0,    32'h0,       0, 32'hDEAD_0001, 0,   1, 32'h10,       0, 32'hA000_000C);
        vecs[11] = mk(0,    32'h0,       0, 32'hDEAD_0002, 0,   1, 32'h10,       0, 32'hA000_000C);
        vecs[12] = mk(0,    32'h0,       1, 32'hB000_0010, 0,   1, 32'h10,       0, 32'hA000_000C);
        vecs[13] = mk(0,    32'h0,       1, 32'h1111_1111, 0,   0, 32'h10,       1, 32'hB000_0010);
        vecs[14] = mk(0,    32'h0,       0, 32'h0,         0,   0, 32'h10,       1, 32'hB000_0010);
        vecs[15] = mk(0,    32'h0,       0, 32'h0,         0,   0, 32'h10,       1, 32'hB000_0010);
        vecs[16] = mk(0,    32'h0,       0, 32'h0,         0,   0, 32'h10,       1, 32'hB000_0010);
        vecs[17] = mk(0,    32'h0,       0, 32'h0,         1,   0, 32'h10,       1, 32'hB000_0010);
        vecs[18] = mk(1'b1, 32'h103,     1, 32'hB000_0014, 0,   1, 32'h14,       0, 32'hB000_0010);
        vecs[19] = mk(0,    32'h0,       1, 32'hC000_0100, 0,   1, 32'h100,      0, 32'hB000_0010);
        vecs[20] = mk(1'b1, 32'h205,     0, 32'h0,         1,   0, 32'h100,      1, 32'hC000_0100);
        vecs[21] = mk(0,    32'h0,       0, 32'h0,         0,   1, 32'h204,      0, 32'hC000_0100);
        vecs[22] = mk(0,    32'h0,       1, 32'hC000_0204, 0,   1, 32'h204,      0, 32'hC000_0100);
        vecs[23] = mk(0,    32'h0,       0, 32'h0,         0,   0, 32'h204,      1, 32'hC000_0204);

        // Reset held with a stray ack: outputs at reset values.
        ImemAck   = 1'b1;
        ImemRData = 32'hBAD0_BAD0;
        step();
        step();
        chk_main("rst", 1'b0, 32'h0, 1'b0, 32'h13);
`ifdef FETCH_ILLEGAL_CHECK_EN
        chk("rst IllegalInstr", {31'd0, IllegalInstr}, 32'd0);
`endif
        ImemAck = 1'b0;
        reset   = 1'b0;

        for (int i = 0; i < NV; i++) begin
            Redirect   = vecs[i].redir;
            PCTarget   = vecs[i].tgt;
            ImemAck    = vecs[i].ack;
            ImemRData  = vecs[i].rdata;
            InstrReady = vecs[i].ready;
            chk_main($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_pc,
                     vecs[i].e_valid, vecs[i].e_instr);
            step();
        end

        // Async reset while VALID: drops the held word at once.
        Redirect   = 1'b0;
        InstrReady = 1'b0;
        ImemAck    = 1'b1;
        ImemRData  = 32'hBAD0_0001;
        chk_main("hold", 1'b0, 32'h204, 1'b1, 32'hC000_0204);
        #2;
        reset = 1'b1;
        #1;
        chk_main("rstV", 1'b0, 32'h0, 1'b0, 32'h13);
        step();
        reset   = 1'b0;
        ImemAck = 1'b0;
        chk_main("relV", 1'b0, 32'h0, 1'b0, 32'h13);
        step();
        chk_main("reqA", 1'b1, 32'h0, 1'b0, 32'h13);

        // Async reset in REQ with an ack arriving during reset.
        #2;
        reset     = 1'b1;
        ImemAck   = 1'b1;
        ImemRData = 32'hBAD0_0002;
        #1;
        chk_main("rstR", 1'b0, 32'h0, 1'b0, 32'h13);
        step();
        chk_main("rstR2", 1'b0, 32'h0, 1'b0, 32'h13);
        reset   = 1'b0;
        ImemAck = 1'b0;
        step();
        chk_main("reqB", 1'b1, 32'h0, 1'b0, 32'h13);

`ifdef FETCH_ILLEGAL_CHECK_EN
        ImemAck   = 1'b1;
        ImemRData = 32'h0000_0037;
        step();
        chk("lui IllegalInstr", {31'd0, IllegalInstr}, 32'd1);
        ImemAck    = 1'b0;
        InstrReady = 1'b1;
        step();
        chk("req IllegalInstr", {31'd0, IllegalInstr}, 32'd0);
        InstrReady = 1'b0;
        ImemAck    = 1'b1;
        ImemRData  = 32'h0000_0013;
        step();
        chk("nop IllegalInstr", {31'd0, IllegalInstr}, 32'd0);
        ImemAck = 1'b0;
`endif

        // PC wrap: RESET_PC=0xFFFFFFFC with ack/ready tied high.
        chk("wrap rst PCF",      pc2,   32'hFFFF_FFFC);
        chk("wrap rst PCPlus4F", pc4_2, 32'h0);
        rst2 = 1'b0;
        chk("wrap idle ImemReq", {31'd0, req2}, 32'd0);
        step();
        chk("wrap req ImemReq",  {31'd0, req2}, 32'd1);
        chk("wrap req ImemAddr", addr2, 32'hFFFF_FFFC);
        step();
        chk("wrap valid",        {31'd0, valid2}, 32'd1);
        chk("wrap valid Instr",  instr2, 32'h13);
        step();
        chk("wrap next ImemAddr", addr2, 32'h0);
        chk("wrap next PCPlus4F", pc4_2, 32'h4);
        chk("wrap next ImemReq",  {31'd0, req2}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, Instr value at reset (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ImemReq  output  1  fetch request to instruction memory.
REQ-006 SHALL have port ImemAddr  output  32  fetch address, equal to PCF.
REQ-007 SHALL have port ImemAck  input  1  memory returns ImemRData this cycle; honoured only while ImemReq=1.
REQ-008 SHALL have port ImemRData  input  32  fetched instruction word.
REQ-009 SHALL have port Redirect  input  1  taken branch/jal from execute.
REQ-010 SHALL have port PCTarget  input  32  redirect target.
REQ-011 SHALL have port Instr  output  32  held instruction; Instr[6:0] drives the main decoder op input.
REQ-012 SHALL have port PCF  output  32  PC of the current fetch or held instruction.
REQ-013 SHALL have port PCPlus4F  output  32  PCF+4.
REQ-014 SHALL have port InstrValid  output  1  Instr is valid for decode.
REQ-015 SHALL have port InstrReady  input  1  decode consumes Instr when InstrValid=1 and InstrReady=1.
REQ-016 SHALL have port IllegalInstr  output  1  held opcode not implemented; present only per REQ-031.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, VALID.
REQ-018 IDLE SHALL drive ImemReq=0 and InstrValid=0, and SHALL move to REQ unconditionally on the next edge.
REQ-019 REQ SHALL drive ImemReq=1 with ImemAddr=PCF and hold it until ImemAck=1; on ImemAck=1 it SHALL capture ImemRData into Instr and move to VALID.
REQ-020 VALID SHALL drive InstrValid=1 and ImemReq=0, and SHALL keep Instr and PCF stable while InstrReady=0.
REQ-021 VALID with InstrReady=1 SHALL set PCF<=PCF+4 and move to REQ; peak throughput is one instruction per 2 cycles.
REQ-022 Redirect=1 in any non-IDLE state SHALL set PCF<={PCTarget[31:2],2'b00} and move to REQ.
REQ-023 Redirect SHALL take priority over InstrReady and ImemAck.
REQ-024 Redirect in VALID SHALL drop the held instruction, so InstrValid=0 on the next cycle.
REQ-025 Redirect and ImemAck together in REQ SHALL discard ImemRData and leave Instr unchanged.
REQ-026 Redirect in IDLE SHALL be ignored.
REQ-027 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000); PCPlus4F SHALL wrap identically.
REQ-028 PCF[1:0] SHALL always be 2'b00.

Reset
REQ-029 While reset=1, outputs SHALL be: state=IDLE, PCF=RESET_PC, Instr=NOP_INSTR, InstrValid=0, ImemReq=0, IllegalInstr=0.
REQ-030 Reset asserted mid-request or while in VALID SHALL abandon the transaction immediately; an ImemAck arriving during reset SHALL be ignored.

Configuration
REQ-031 Macro FETCH_ILLEGAL_CHECK_EN defined: IllegalInstr SHALL be 1 whenever InstrValid=1 and Instr[6:0] is not one of 0000011, 0100011, 0110011, 1100011, 0010011, 1101111; otherwise 0.
REQ-032 Macro FETCH_ILLEGAL_CHECK_EN undefined: the IllegalInstr port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-033 Shared package riscv_pkg SHALL hold the opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL), NOP_INSTR and the fetch FSM state enum.
REQ-034 Opcode legality SHALL be a combinational sub-module, instr_legal_chk (op[6:0] -> legal), instantiated only under FETCH_ILLEGAL_CHECK_EN.

Verification
REQ-035 Release reset with ImemAck tied 1 and InstrReady tied 1 -> ImemAddr sequence 0x0, 0x4, 0x8, with InstrValid pulsing every 2nd cycle.
REQ-036 ImemAck delayed 3 cycles at PC 0x10 -> ImemReq held 1 with ImemAddr=0x10 stable, then InstrValid=1 with Instr=ImemRData.
REQ-037 InstrReady=0 for 4 cycles in VALID -> Instr, PCF and InstrValid stable; advance to PC 0x14 on the cycle after InstrReady=1.
REQ-038 Redirect=1 with PCTarget=0x103 at the same cycle as ImemAck -> data discarded, next ImemAddr=0x100, Instr unchanged.
REQ-039 RESET_PC=0xFFFF_FFFC with one handshake completed -> next ImemAddr=0x0.
REQ-040 With FETCH_ILLEGAL_CHECK_EN defined, fetch word 0x0000_0037 (lui) -> IllegalInstr=1 while VALID; fetch 0x0000_0013 -> IllegalInstr=0.
